// File: rtl/decode_queue.sv
// decode_queue: buffered RV32I/M decode stage between fetch and issue.
// Fetch pushes {instr, pc} into a FIFO; the decoded head is registered.
//
// Ports:
//   clk, rst_n, flush         clock, async active-low reset, sync flush
//   in_valid/in_ready         fetch handshake, D_instruction, D_pc
//   out_valid/out_ready       issue handshake for the decoded bundle
//   D_count                   FIFO occupancy
//   D_* / is_* / illegal      registered decode results
module decode_queue #(
  parameter int ADDRESS_SIZE     = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int DEPTH            = 4,
  parameter bit ENABLE_MUL       = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDRESS_SIZE-1:0]     D_instruction,
  input  logic [ADDRESS_SIZE-1:0]     D_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      D_count,
  output logic [REG_ADDRESS_SIZE-1:0] D_addr_r1,
  output logic [REG_ADDRESS_SIZE-1:0] D_addr_r2,
  output logic [REG_ADDRESS_SIZE-1:0] D_dest,
  output logic [2:0]                  D_funct3,
  output logic                        D_We,
  output logic                        D_op,
  output logic [ADDRESS_SIZE-1:0]     D_immediate,
  output logic                        D_Ie,
  output logic                        D_b,
  output logic                        D_jalr,
  output logic [ADDRESS_SIZE-1:0]     D_bTarget,
  output logic [ADDRESS_SIZE-1:0]     D_link,
  output logic                        is_mul,
  output logic                        is_alu,
  output logic                        is_mem,
  output logic                        illegal
);

  localparam int AW = ADDRESS_SIZE;
  localparam int RW = REG_ADDRESS_SIZE;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
    logic [RW-1:0] dest;
    logic [2:0]    f3;
    logic          we;
    logic          op;
    logic [AW-1:0] imm;
    logic          ie;
    logic          b;
    logic          jalr;
    logic [AW-1:0] tgt;
    logic [AW-1:0] link;
    logic          mul;
    logic          alu;
    logic          mem;
    logic          ill;
  } dec_t;

  logic [AW-1:0] mem_instr [DEPTH];
  logic [AW-1:0] mem_pc    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          empty;

  assign in_ready = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !empty && (!out_valid || out_ready) && !flush;
  assign D_count  = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= D_instruction;
      mem_pc[wr_ptr]    <= D_pc;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic [AW-1:0] h;
  logic [AW-1:0] hp;
  logic [AW-1:0] i_imm;
  logic [AW-1:0] s_imm;
  logic [AW-1:0] b_imm;
  logic [AW-1:0] j_imm;
  logic [AW-1:0] u_imm;
  logic [6:0]    opc;
  logic op_rr, op_ir, op_lr, op_sr;
  logic op_br, op_jal, op_jalr;
  logic op_lui, op_auipc;
  dec_t dec;
  dec_t dq;

  assign h   = mem_instr[rd_ptr];
  assign hp  = mem_pc[rd_ptr];
  assign opc = h[6:0];

  assign i_imm = {{(AW-12){h[31]}}, h[31:20]};
  assign s_imm = {{(AW-12){h[31]}}, h[31:25], h[11:7]};
  assign b_imm = {{(AW-13){h[31]}}, h[31], h[7],
                  h[30:25], h[11:8], 1'b0};
  assign j_imm = {{(AW-21){h[31]}}, h[31], h[19:12],
                  h[20], h[30:21], 1'b0};
  assign u_imm = {h[31:12], 12'b0};

  assign op_rr    = (opc == 7'b0110011);
  assign op_ir    = (opc == 7'b0010011);
  assign op_lr    = (opc == 7'b0000011);
  assign op_sr    = (opc == 7'b0100011);
  assign op_br    = (opc == 7'b1100011);
  assign op_jal   = (opc == 7'b1101111);
  assign op_jalr  = (opc == 7'b1100111);
  assign op_lui   = (opc == 7'b0110111);
  assign op_auipc = (opc == 7'b0010111);

  always_comb begin
    dec      = '0;
    dec.r1   = h[19:15];
    dec.r2   = h[24:20];
    dec.dest = h[11:7];
    dec.f3   = h[14:12];
    dec.link = hp + AW'(4);
    unique case (1'b1)
      op_rr: begin
        dec.we  = 1'b1;
        dec.op  = h[30];
        dec.mul = h[25];
        dec.ill = h[25] && !ENABLE_MUL;
      end
      op_ir: begin
        dec.we  = 1'b1;
        dec.ie  = 1'b1;
        dec.imm = i_imm;
      end
      op_lr: begin
        dec.we  = 1'b1;
        dec.ie  = 1'b1;
        dec.imm = i_imm;
        dec.mem = 1'b1;
      end
      op_sr: begin
        dec.ie  = 1'b1;
        dec.imm = s_imm;
        dec.mem = 1'b1;
      end
      op_br: begin
        dec.op  = 1'b1;
        dec.imm = b_imm;
        dec.b   = 1'b1;
        dec.tgt = hp + b_imm;
      end
      op_jal: begin
        dec.we  = 1'b1;
        dec.imm = j_imm;
        dec.b   = 1'b1;
        dec.tgt = hp + j_imm;
      end
      op_jalr: begin
        dec.we   = 1'b1;
        dec.ie   = 1'b1;
        dec.imm  = i_imm;
        dec.b    = 1'b1;
        dec.jalr = 1'b1;
      end
      op_lui: begin
        dec.we  = 1'b1;
        dec.ie  = 1'b1;
        dec.imm = u_imm;
      end
      op_auipc: begin
        // AUIPC result rides in the target field, not a branch.
        dec.we  = 1'b1;
        dec.ie  = 1'b1;
        dec.imm = u_imm;
        dec.tgt = hp + u_imm;
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.dest == '0) dec.we = 1'b0;
    dec.alu = !dec.mul && !dec.mem && !dec.ill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dq        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      dq        <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign D_addr_r1   = dq.r1;
  assign D_addr_r2   = dq.r2;
  assign D_dest      = dq.dest;
  assign D_funct3    = dq.f3;
  assign D_We        = dq.we;
  assign D_op        = dq.op;
  assign D_immediate = dq.imm;
  assign D_Ie        = dq.ie;
  assign D_b         = dq.b;
  assign D_jalr      = dq.jalr;
  assign D_bTarget   = dq.tgt;
  assign D_link      = dq.link;
  assign is_mul      = dq.mul;
  assign is_alu      = dq.alu;
  assign is_mem      = dq.mem;
  assign illegal     = dq.ill;

endmodule
